// File: rtl/run_monitor.sv
// End-of-run controller: counts RUN cycles, stops on exception/stop/budget, then streams the register file out.
// Build option: define RUN_MONITOR_WATCHDOG_EN to enable the MAX_CYCLES timeout trigger.
module run_monitor #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_CYCLES = 30,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              except,
    input  logic              stop,
    output logic [IDX_W-1:0]  rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              halted,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_index,
    output logic [DATA_W-1:0] dump_value,
    output logic [1:0]        cause,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              finished
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0]       CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0]       CAUSE_EXCEPT  = 2'b10;
    localparam logic [1:0]       CAUSE_STOP    = 2'b11;
    localparam logic [CNT_W-1:0] LAST_CYCLE    = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_REGS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             timeout;

`ifdef RUN_MONITOR_WATCHDOG_EN
    assign timeout = (cnt_q == LAST_CYCLE);
`else
    // Budget is irrelevant without the watchdog; the counter simply saturates.
    logic watchdog_unused;
    assign watchdog_unused = ^LAST_CYCLE;
    assign timeout         = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        halted     = 1'b0;
        dump_valid = 1'b0;
        finished   = 1'b0;
        rf_addr    = '0;
        dump_index = '0;
        dump_value = '0;

        unique case (state_q)
            RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (except) begin
                    cause_d = CAUSE_EXCEPT;
                end else if (stop) begin
                    cause_d = CAUSE_STOP;
                end else if (timeout) begin
                    cause_d = CAUSE_TIMEOUT;
                end
                if (except || stop || timeout) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                halted     = 1'b1;
                dump_valid = 1'b1;
                rf_addr    = idx_q;
                dump_index = idx_q;
                dump_value = rf_data;
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                halted   = 1'b1;
                finished = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous and wins over any trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            idx_q   <= '0;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign cause       = cause_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: random register contents and handshakes checked against a queue-based model.
module tb_run_monitor;

    localparam int NR = 8;
    localparam int DW = 16;
    localparam int MC = 30;
    localparam int CW = 8;
    localparam int IW = $clog2(NR);
`ifdef RUN_MONITOR_WATCHDOG_EN
    localparam bit WATCHDOG = 1'b1;
`else
    localparam bit WATCHDOG = 1'b0;
`endif
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, except, stop, dump_ready;
    logic [IW-1:0] rf_addr, dump_index;
    logic [DW-1:0] rf_data, dump_value;
    logic          halted, dump_valid, finished;
    logic [1:0]    cause;
    logic [CW-1:0] cycle_count;
    logic [DW-1:0] rf [NR];

    run_monitor #(
        .NUM_REGS(NR), .DATA_W(DW), .MAX_CYCLES(MC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .except(except), .stop(stop),
        .rf_addr(rf_addr), .rf_data(rf_data), .halted(halted),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_index(dump_index), .dump_value(dump_value),
        .cause(cause), .cycle_count(cycle_count), .finished(finished)
    );

    always #5 clk = ~clk;
    assign rf_data = rf[rf_addr];

    // Model: whether the run has ended, cycles counted, latched cause, and beats still owed.
    bit         m_ended = 1'b0;
    int         m_count = 0;
    logic [1:0] m_cause = 2'b00;
    int         exp_q[$];
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        bit v;
        int idx;
        v   = m_ended && (exp_q.size() > 0);
        idx = v ? exp_q[0] : 0;
        check("halted",      32'(halted),      32'(m_ended));
        check("dump_valid",  32'(dump_valid),  32'(v));
        check("finished",    32'(finished),    32'(m_ended && !v));
        check("cause",       32'(cause),       32'(m_cause));
        check("cycle_count", 32'(cycle_count), 32'(m_count));
        check("dump_index",  32'(dump_index),  32'(idx));
        check("rf_addr",     32'(rf_addr),     32'(idx));
        check("dump_value",  32'(dump_value),  v ? 32'(rf[idx]) : 32'd0);
    endtask

    task automatic model_step();
        bit wd;
        if (reset) begin
            m_ended = 1'b0;
            m_count = 0;
            m_cause = 2'b00;
            exp_q.delete();
        end else if (!m_ended) begin
            wd = WATCHDOG && (m_count == MC - 1);
            if (m_count < CNT_SAT) m_count++;
            if (except)    m_cause = 2'b10;
            else if (stop) m_cause = 2'b11;
            else if (wd)    m_cause = 2'b01;
            if (except || stop || wd) begin
                m_ended = 1'b1;
                for (int i = 0; i < NR; i++) exp_q.push_back(i);
            end
        end else if (exp_q.size() > 0 && dump_ready) begin
            void'(exp_q.pop_front());
        end
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. rst_idx >= 0 resets once mid-dump at that index.
    task automatic scenario(input int exc_at, input int stp_at, input int rdy_mode, input int rst_idx);
        int cyc;
        int tail;
        bit did_rst;
        cyc  = 0;
        tail = 0;
        foreach (rf[i]) rf[i] = DW'($urandom);
        reset = 1'b1; except = 1'b0; stop = 1'b0; dump_ready = 1'b0;
        @(posedge clk); model_step(); #1;
        for (int t = 0; t < 1500 && tail < 3; t++) begin
            cyc++;
            did_rst = 1'b0;
            reset   = 1'b0;
            if (!m_ended) begin
                except = (cyc == exc_at);
                stop   = (cyc == stp_at);
            end else begin
                except = 1'($urandom);
                stop   = 1'($urandom);
            end
            case (rdy_mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: dump_ready = 1'($urandom);
            endcase
            if (rst_idx >= 0 && m_ended && exp_q.size() > 0 && exp_q[0] == rst_idx) begin
                reset   = 1'b1;
                rst_idx = -1;
                did_rst = 1'b1;
            end
            @(negedge clk); compare_all();
            @(posedge clk); model_step(); #1;
            if (did_rst) cyc = 0;
            if (m_ended && exp_q.size() == 0) tail++;
        end
        check("run_completed", 32'(tail >= 3), 32'd1);
    endtask

    initial begin
        reset = 1'b1; except = 1'b0; stop = 1'b0; dump_ready = 1'b0;
        foreach (rf[i]) rf[i] = DW'($urandom);
        repeat (2) begin @(posedge clk); model_step(); #1; end
        @(negedge clk); compare_all();

        // Budget run (stop at 45 stands in when the watchdog is absent).
        scenario(-1, WATCHDOG ? -1 : 45, 0, -1);
        check("budget_cause", 32'(cause), WATCHDOG ? 32'd1 : 32'd3);
        check("budget_count", 32'(cycle_count), WATCHDOG ? 32'd30 : 32'd45);

        // Exception and stop together at cycle 5.
        scenario(5, 5, 0, -1);
        check("except_cause", 32'(cause), 32'd2);
        check("except_count", 32'(cycle_count), 32'd5);

        // Backpressure 1,0,0,1.
        scenario(-1, 12, 1, -1);
        check("bp_count", 32'(cycle_count), 32'd12);

        // Reset mid-dump, then a fresh run stopped at cycle 4.
        scenario(-1, 4, 0, 5);
        check("rst_cause", 32'(cause), 32'd3);
        check("rst_count", 32'(cycle_count), 32'd4);

        // Stop at 100: past the budget.
        scenario(-1, 100, 0, -1);
        check("late_stop_cause", 32'(cause), WATCHDOG ? 32'd1 : 32'd3);
        check("late_stop_count", 32'(cycle_count), WATCHDOG ? 32'd30 : 32'd100);

        // Stop at 300: counter saturation without the watchdog.
        scenario(-1, 300, 2, -1);
        check("sat_count", 32'(cycle_count), WATCHDOG ? 32'd30 : 32'(CNT_SAT));

        repeat (3) begin
            scenario(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), 2,
                     int'($urandom_range(0, NR)) - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
